// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for the two-requester memory arbiter: core and loader ports,
// the shared memory port, and arbiter status.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [1:0]        grant;
    logic              busy;

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output grant, busy
    );

    // Requesters and memory side
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  grant, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between the
// MIPS core (port 0) and a loader/debug master (port 1). All outputs registered.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t            state_q, state_nxt;
    logic [2:0]        cnt_q, cnt_nxt;
    logic              last_q, last_nxt;
    logic              we_q, we_nxt;
    logic [1:0]        grant_q, grant_nxt;
    logic              busy_q, busy_nxt;
    logic              en_q, en_nxt;
    logic              mwe_q, mwe_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    logic              ack0_q, ack0_nxt;
    logic              ack1_q, ack1_nxt;
    logic [DATA_W-1:0] rdata0_q, rdata0_nxt;
    logic [DATA_W-1:0] rdata1_q, rdata1_nxt;
    logic              win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            grant_q  <= 2'b00;
            busy_q   <= 1'b0;
            en_q     <= 1'b0;
            mwe_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            last_q   <= last_nxt;
            we_q     <= we_nxt;
            grant_q  <= grant_nxt;
            busy_q   <= busy_nxt;
            en_q     <= en_nxt;
            mwe_q    <= mwe_nxt;
            addr_q   <= addr_nxt;
            wdata_q  <= wdata_nxt;
            ack0_q   <= ack0_nxt;
            ack1_q   <= ack1_nxt;
            rdata0_q <= rdata0_nxt;
            rdata1_q <= rdata1_nxt;
        end
    end

    // Outputs are computed for the state being entered, so each registered
    // output lines up with its state without any input-to-output path.
    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        last_nxt   = last_q;
        we_nxt     = we_q;
        grant_nxt  = grant_q;
        en_nxt     = 1'b0;
        mwe_nxt    = 1'b0;
        addr_nxt   = addr_q;
        wdata_nxt  = wdata_q;
        ack0_nxt   = 1'b0;
        ack1_nxt   = 1'b0;
        rdata0_nxt = rdata0_q;
        rdata1_nxt = rdata1_q;
        win        = 1'b0;

        case (state_q)
            IDLE: begin
                grant_nxt = 2'b00;
                if (bus.m0_req || bus.m1_req) begin
                    // On a tie the port not served last wins
                    win       = (bus.m0_req && bus.m1_req) ? ~last_q : bus.m1_req;
                    last_nxt  = win;
                    we_nxt    = win ? bus.m1_we    : bus.m0_we;
                    addr_nxt  = win ? bus.m1_addr  : bus.m0_addr;
                    wdata_nxt = win ? bus.m1_wdata : bus.m0_wdata;
                    en_nxt    = 1'b1;
                    mwe_nxt   = win ? bus.m1_we : bus.m0_we;
                    grant_nxt = win ? 2'b10 : 2'b01;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                cnt_nxt   = 3'(MEM_LAT);
                state_nxt = WAIT;
            end
            WAIT: begin
                cnt_nxt = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_nxt = RESP;
                    if (last_q) begin
                        ack1_nxt = 1'b1;
                        if (!we_q) rdata1_nxt = bus.mem_rdata;
                    end else begin
                        ack0_nxt = 1'b1;
                        if (!we_q) rdata0_nxt = bus.mem_rdata;
                    end
                end
            end
            RESP: begin
                grant_nxt = 2'b00;
                state_nxt = IDLE;
            end
            default: begin
                grant_nxt = 2'b00;
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    assign bus.m0_ack    = ack0_q;
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_ack    = ack1_q;
    assign bus.m1_rdata  = rdata1_q;
    assign bus.mem_en    = en_q;
    assign bus.mem_we    = mwe_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one instance at MEM_LAT=1, one at
// MEM_LAT=3, each attached to a small behavioural memory.
module tb_mem_bus_arbiter;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memories reload their contents whenever reset is held; off-cycle read
    // data is a poison value so a mistimed capture is visible.
    logic [31:0] mem1 [0:15];
    logic [31:0] mem3 [0:15];
    logic [31:0] rd1_q;
    logic [31:0] p3 [0:2];

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) mem1[i] <= 32'hA000_0000 | 32'(i);
            mem1[4] <= 32'hCAFE_0004;
            rd1_q   <= 32'h0BAD_0BAD;
        end else begin
            rd1_q <= 32'h0BAD_0BAD;
            if (bus1.mem_en) begin
                if (bus1.mem_we) mem1[bus1.mem_addr[3:0]] <= bus1.mem_wdata;
                else             rd1_q <= mem1[bus1.mem_addr[3:0]];
            end
        end
    end
    assign bus1.mem_rdata = rd1_q;

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) mem3[i] <= 32'hB000_0000 | 32'(i);
            mem3[4] <= 32'hBEEF_0004;
            for (int j = 0; j < 3; j++) p3[j] <= 32'h0BAD_0BAD;
        end else begin
            p3[0] <= (bus3.mem_en && !bus3.mem_we) ? mem3[bus3.mem_addr[3:0]] : 32'h0BAD_0BAD;
            p3[1] <= p3[0];
            p3[2] <= p3[1];
            if (bus3.mem_en && bus3.mem_we) mem3[bus3.mem_addr[3:0]] <= bus3.mem_wdata;
        end
    end
    assign bus3.mem_rdata = p3[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle1(input string tag);
        chk({tag, ".m0_ack"},    32'(bus1.m0_ack),   0);
        chk({tag, ".m1_ack"},    32'(bus1.m1_ack),   0);
        chk({tag, ".m0_rdata"},  bus1.m0_rdata,      0);
        chk({tag, ".m1_rdata"},  bus1.m1_rdata,      0);
        chk({tag, ".mem_en"},    32'(bus1.mem_en),   0);
        chk({tag, ".mem_we"},    32'(bus1.mem_we),   0);
        chk({tag, ".mem_addr"},  bus1.mem_addr,      0);
        chk({tag, ".mem_wdata"}, bus1.mem_wdata,     0);
        chk({tag, ".grant"},     32'(bus1.grant),    0);
        chk({tag, ".busy"},      32'(bus1.busy),     0);
        chk({tag, ".busy3"},     32'(bus3.busy),     0);
        chk({tag, ".grant3"},    32'(bus3.grant),    0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b0;
        bus1.m0_req = 0; bus1.m0_we = 0; bus1.m0_addr = 0; bus1.m0_wdata = 0;
        bus1.m1_req = 0; bus1.m1_we = 0; bus1.m1_addr = 0; bus1.m1_wdata = 0;
        bus3.m0_req = 0; bus3.m0_we = 0; bus3.m0_addr = 0; bus3.m0_wdata = 0;
        bus3.m1_req = 0; bus3.m1_we = 0; bus3.m1_addr = 0; bus3.m1_wdata = 0;

        // Reset held with random requests
        repeat (4) begin
            bus1.m0_req = 1'($urandom); bus1.m0_we = 1'($urandom);
            bus1.m0_addr = $urandom;    bus1.m0_wdata = $urandom;
            bus1.m1_req = 1'($urandom); bus1.m1_we = 1'($urandom);
            bus1.m1_addr = $urandom;    bus1.m1_wdata = $urandom;
            bus3.m0_req = 1'($urandom); bus3.m1_req = 1'($urandom);
            tick();
            chk_idle1("rst_held");
        end
        bus1.m0_req = 0; bus1.m0_we = 0; bus1.m0_addr = 0; bus1.m0_wdata = 0;
        bus1.m1_req = 0; bus1.m1_we = 0; bus1.m1_addr = 0; bus1.m1_wdata = 0;
        bus3.m0_req = 0; bus3.m1_req = 0;
        rst = 1'b1;
        repeat (3) tick();
        chk_idle1("rst_released");

        // Single read on port 0, MEM_LAT=1
        bus1.m0_req = 1; bus1.m0_we = 0; bus1.m0_addr = 4;
        tick();
        chk("rd.c1.mem_en",   32'(bus1.mem_en), 1);
        chk("rd.c1.mem_we",   32'(bus1.mem_we), 0);
        chk("rd.c1.mem_addr", bus1.mem_addr,    4);
        chk("rd.c1.grant",    32'(bus1.grant),  1);
        chk("rd.c1.busy",     32'(bus1.busy),   1);
        tick();
        chk("rd.c2.mem_en",   32'(bus1.mem_en), 0);
        chk("rd.c2.grant",    32'(bus1.grant),  1);
        chk("rd.c2.m0_ack",   32'(bus1.m0_ack), 0);
        tick();
        chk("rd.c3.m0_ack",   32'(bus1.m0_ack), 1);
        chk("rd.c3.m0_rdata", bus1.m0_rdata,    32'hCAFE_0004);
        chk("rd.c3.m1_ack",   32'(bus1.m1_ack), 0);
        chk("rd.c3.grant",    32'(bus1.grant),  1);
        bus1.m0_req = 0;
        tick();
        chk("rd.c4.busy",     32'(bus1.busy),   0);
        chk("rd.c4.grant",    32'(bus1.grant),  0);
        chk("rd.c4.m0_ack",   32'(bus1.m0_ack), 0);
        chk("rd.c4.mem_addr", bus1.mem_addr,    4);

        // Port 1 write of address 8 followed directly by a read of it
        bus1.m1_req = 1; bus1.m1_we = 1; bus1.m1_addr = 8; bus1.m1_wdata = 32'h1234_5678;
        tick();
        chk("wr.c1.mem_en",    32'(bus1.mem_en), 1);
        chk("wr.c1.mem_we",    32'(bus1.mem_we), 1);
        chk("wr.c1.mem_wdata", bus1.mem_wdata,   32'h1234_5678);
        chk("wr.c1.grant",     32'(bus1.grant),  2);
        tick();
        chk("wr.c2.mem_we",    32'(bus1.mem_we), 0);
        tick();
        chk("wr.c3.m1_ack",    32'(bus1.m1_ack), 1);
        chk("wr.c3.m1_rdata",  bus1.m1_rdata,    0);
        bus1.m1_we = 0;
        tick();
        chk("wr.c4.busy",      32'(bus1.busy),   0);
        chk("wr.c4.mem_wdata", bus1.mem_wdata,   32'h1234_5678);
        tick();
        chk("rb.c1.mem_en",    32'(bus1.mem_en), 1);
        chk("rb.c1.mem_we",    32'(bus1.mem_we), 0);
        chk("rb.c1.grant",     32'(bus1.grant),  2);
        tick();
        tick();
        chk("rb.c3.m1_ack",    32'(bus1.m1_ack), 1);
        chk("rb.c3.m1_rdata",  bus1.m1_rdata,    32'h1234_5678);
        bus1.m1_req = 0;
        tick();

        // Both ports requesting continuously: grants alternate from port 0
        bus1.m0_req = 1; bus1.m0_we = 0; bus1.m0_addr = 4;
        bus1.m1_req = 1; bus1.m1_we = 0; bus1.m1_addr = 8;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr.grant", 32'(bus1.grant), (k % 2 == 0) ? 1 : 2);
            tick();
            tick();
            chk("rr.m0_ack", 32'(bus1.m0_ack), 32'(k % 2 == 0));
            chk("rr.m1_ack", 32'(bus1.m1_ack), 32'(k % 2 == 1));
            if (k % 2 == 0) chk("rr.m0_rdata", bus1.m0_rdata, 32'hCAFE_0004);
            else            chk("rr.m1_rdata", bus1.m1_rdata, 32'h1234_5678);
            if (k == 3) begin
                bus1.m0_req = 0;
                bus1.m1_req = 0;
            end
            tick();
            chk("rr.idle_grant", 32'(bus1.grant), 0);
        end

        // MEM_LAT=3 single read on the second instance
        bus3.m0_req = 1; bus3.m0_we = 0; bus3.m0_addr = 4;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("lat3.mem_en", 32'(bus3.mem_en), 32'(i == 1));
            chk("lat3.m0_ack", 32'(bus3.m0_ack), 32'(i == 5));
            chk("lat3.busy",   32'(bus3.busy),   32'(i <= 5));
            if (i == 5) begin
                chk("lat3.m0_rdata", bus3.m0_rdata, 32'hBEEF_0004);
                bus3.m0_req = 0;
            end
        end

        // Reset asserted during WAIT abandons the access
        bus1.m0_req = 1; bus1.m0_we = 0; bus1.m0_addr = 4;
        tick();
        chk("mid.c1.grant", 32'(bus1.grant), 1);
        tick();
        chk("mid.c2.busy",  32'(bus1.busy),  1);
        #2;
        rst = 1'b0;
        #1;
        chk_idle1("mid_rst");
        bus1.m1_req = 1; bus1.m1_we = 0; bus1.m1_addr = 8;
        tick();
        chk("mid.held.m0_ack", 32'(bus1.m0_ack), 0);
        chk("mid.held.busy",   32'(bus1.busy),   0);
        tick();
        rst = 1'b1;
        tick();
        chk("post.grant",    32'(bus1.grant), 1);
        tick();
        tick();
        chk("post.m0_ack",   32'(bus1.m0_ack), 1);
        chk("post.m0_rdata", bus1.m0_rdata,    32'hCAFE_0004);
        bus1.m0_req = 0;
        tick();
        tick();
        chk("post.m1_grant", 32'(bus1.grant), 2);
        tick();
        tick();
        chk("post.m1_ack",   32'(bus1.m1_ack), 1);
        chk("post.m1_rdata", bus1.m1_rdata,    32'hA000_0008);
        bus1.m1_req = 0;
        tick();
        chk("post.busy",     32'(bus1.busy),   0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
